analog_test_sequencer: RTL and testbench

Parametrised controller that routes one analog test structure at a time onto the tile's analog pins. It drives one-hot switch enables with break-before-make dead time and a programmable dwell per channel, and supports single, scan, continuous and hold modes. It sits inside the tile top level, between the digital config inputs (`ui_in`/`uio_in`) and the analog switch-enable nets. It generalises the bare analog tile top into a reusable N-channel sequencer.

---
 rtl/analog_test_pkg.sv | 19 +
 rtl/analog_test_sequencer_bbm_timer.sv | 31 +++
 rtl/analog_test_sequencer.sv | 174 +++++++++++++++++
 tb/tb_analog_test_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/analog_test_pkg.sv
// Shared types for the analog test sequencer: run modes, FSM states, index width.
package analog_test_pkg;

  localparam int CH_IDX_W = 3;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_CONT   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DEAD  = 2'b01,
    ST_DWELL = 2'b10
  } state_e;

endpackage

// File: rtl/analog_test_sequencer_bbm_timer.sv
// Loadable down-counter shared by the dead-time and dwell phases.
// tc is high while the count sits at zero; load wins over counting.
module bbm_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          load,
  input  logic          run,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ena) begin
      if (load) begin
        r_cnt <= load_val;
      end else if (run && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign tc = (r_cnt == '0);

endmodule

// File: rtl/analog_test_sequencer.sv
// Routes one analog test structure at a time onto the pins with break-before-make
// dead time and a per-channel dwell; SINGLE, SCAN, CONT and HOLD run modes.
module analog_test_sequencer
  import analog_test_pkg::*;
#(
  parameter int N_CH     = 6,
  parameter int DW       = 8,
  parameter int DEAD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [CH_IDX_W-1:0] ch_first,
  input  logic [CH_IDX_W-1:0] ch_last,
  input  logic [DW-1:0]       dwell,
  output logic [N_CH-1:0]     sel_oh,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic                busy,
  output logic                done,
  output logic                frame_tick,
  output logic                cfg_err
);

  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int CW     = (DW > DEAD_W) ? DW : DEAD_W;
  localparam int IDX_W1 = CH_IDX_W + 1;
  localparam logic [CW-1:0]     DEAD_LOAD = CW'(DEAD_CYC - 1);
  localparam logic [IDX_W1-1:0] N_CH_L    = IDX_W1'(N_CH);

  state_e              r_state;
  mode_e               r_mode;
  logic [CH_IDX_W-1:0] r_first;
  logic [CH_IDX_W-1:0] r_last;
  logic [DW-1:0]       r_dwell;
  logic [N_CH-1:0]     r_sel_oh;
  logic [CH_IDX_W-1:0] r_ch_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_frame_tick;
  logic                r_cfg_err;

  logic                w_tc;
  logic                w_load;
  logic                w_run;
  logic                w_range_ok;
  logic                w_at_last;
  logic [CW-1:0]       w_load_val;
  logic [CW-1:0]       w_dwell_load;
  logic [N_CH-1:0]     w_onehot;

  // SINGLE/HOLD only ever touch ch_first, so ch_last is not validated for them.
  always_comb begin
    w_range_ok = ({1'b0, ch_first} < N_CH_L);
    if ((mode == MODE_SCAN) || (mode == MODE_CONT)) begin
      w_range_ok = w_range_ok && (ch_first <= ch_last) && ({1'b0, ch_last} < N_CH_L);
    end
  end

  assign w_dwell_load = (r_dwell == '0) ? '0 : (CW'(r_dwell) - 1'b1);
  assign w_onehot     = N_CH'(1) << r_ch_idx;
  assign w_at_last    = (r_ch_idx == r_last);
  assign w_run        = (r_state == ST_DEAD) || ((r_state == ST_DWELL) && (r_mode != MODE_HOLD));

  // Timer holds (phase length - 1) and is reloaded on every phase entry.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = DEAD_LOAD;
    case (r_state)
      ST_IDLE:  w_load = start && !stop && w_range_ok;
      ST_DEAD:  begin
        w_load     = w_tc;
        w_load_val = w_dwell_load;
      end
      ST_DWELL: w_load = w_tc && (r_mode != MODE_HOLD);
      default:  w_load = 1'b0;
    endcase
  end

  bbm_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (w_load),
    .run      (w_run),
    .load_val (w_load_val),
    .tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_SINGLE;
      r_first      <= '0;
      r_last       <= '0;
      r_dwell      <= '0;
      r_sel_oh     <= '0;
      r_ch_idx     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else if (!ena) begin
      r_done       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (w_range_ok) begin
              r_mode   <= mode_e'(mode);
              r_first  <= ch_first;
              r_last   <= ch_last;
              r_dwell  <= dwell;
              r_ch_idx <= ch_first;
              r_busy   <= 1'b1;
              r_state  <= ST_DEAD;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_tc) begin
            r_state  <= ST_DWELL;
            r_sel_oh <= w_onehot;
          end
        end
        ST_DWELL: begin
          if (stop) begin
            r_state  <= ST_IDLE;
            r_sel_oh <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (w_tc && (r_mode != MODE_HOLD)) begin
            r_sel_oh <= '0;
            if ((r_mode == MODE_SINGLE) || ((r_mode == MODE_SCAN) && w_at_last)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DEAD;
              if (w_at_last) begin
                r_ch_idx     <= r_first;
                r_frame_tick <= 1'b1;
              end else begin
                r_ch_idx <= r_ch_idx + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel_oh     = r_sel_oh;
  assign ch_idx     = r_ch_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign frame_tick = r_frame_tick;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_analog_test_sequencer.sv
// Randomised and directed runs of analog_test_sequencer against a per-cycle
// expected trace built from the channel/dead/dwell timing rules.
module tb_analog_test_sequencer;

  localparam int NCH = 6;
  localparam int DW  = 8;
  localparam int DC  = 2;
  localparam int M_SINGLE = 0;
  localparam int M_SCAN   = 1;
  localparam int M_CONT   = 2;
  localparam int M_HOLD   = 3;

  typedef struct packed {
    logic [5:0] sel;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       ft;
    logic       cerr;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = '0;
  logic [2:0]    ch_first = '0;
  logic [2:0]    ch_last = '0;
  logic [DW-1:0] dwell = '0;
  logic [NCH-1:0] sel_oh;
  logic [2:0]    ch_idx;
  logic          busy;
  logic          done;
  logic          frame_tick;
  logic          cfg_err;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cur_idx = 0;
  obs_t exp_q[$];

  analog_test_sequencer #(.N_CH(NCH), .DW(DW), .DEAD_CYC(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .ch_first   (ch_first),
    .ch_last    (ch_last),
    .dwell      (dwell),
    .sel_oh     (sel_oh),
    .ch_idx     (ch_idx),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  function automatic obs_t cur_obs();
    obs_t o;
    o.sel  = sel_oh;
    o.idx  = ch_idx;
    o.busy = busy;
    o.done = done;
    o.ft   = frame_tick;
    o.cerr = cfg_err;
    return o;
  endfunction

  function automatic obs_t mk(input int sel, input int idx, input bit b, input bit d,
                              input bit ft, input bit ce);
    obs_t o;
    o.sel  = 6'(sel);
    o.idx  = 3'(idx);
    o.busy = b;
    o.done = d;
    o.ft   = ft;
    o.cerr = ce;
    return o;
  endfunction

  function automatic bit cfg_valid(input int m, input int f, input int l);
    if (m == M_SINGLE || m == M_HOLD) return f < NCH;
    return (f <= l) && (l < NCH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    mode     = 2'($urandom_range(0, 3));
    ch_first = 3'($urandom_range(0, 7));
    ch_last  = 3'($urandom_range(0, 7));
    dwell    = DW'($urandom_range(0, 255));
  endtask

  // Expected outputs after each edge, index 0 = the accepted start edge.
  task automatic build(input int m, input int f, input int l, input int dw);
    int d, hi, frames;
    d      = (dw == 0) ? 1 : dw;
    hi     = (m == M_SCAN || m == M_CONT) ? l : f;
    frames = (m == M_CONT) ? 30 : 1;
    exp_q.delete();
    for (int fr = 0; fr < frames; fr++) begin
      for (int ch = f; ch <= hi; ch++) begin
        for (int k = 0; k < DC; k++)
          exp_q.push_back(mk(0, ch, 1, 0, (fr > 0 && ch == f && k == 0), 0));
        for (int k = 0; k < ((m == M_HOLD) ? 400 : d); k++)
          exp_q.push_back(mk(1 << ch, ch, 1, 0, 0, 0));
      end
    end
    if (m == M_SINGLE || m == M_SCAN) exp_q.push_back(mk(0, hi, 0, 1, 0, 0));
  endtask

  task automatic run(input int m, input int f, input int l, input int dw,
                     input int stop_at, input int frz_at, input int frz_len, input string tag);
    obs_t e;
    obs_t prev;
    mode = 2'(m); ch_first = 3'(f); ch_last = 3'(l); dwell = DW'(dw);
    ena = 1'b1; stop = 1'b0; start = 1'b1;
    if (!cfg_valid(m, f, l)) begin
      step();
      start = 1'b0;
      scramble_cfg();
      chk({tag, "_cerr"}, 32'(cur_obs()), 32'(mk(0, cur_idx, 0, 0, 0, 1)));
      step();
      chk({tag, "_cerr_end"}, 32'(cur_obs()), 32'(mk(0, cur_idx, 0, 0, 0, 0)));
      return;
    end
    build(m, f, l, dw);
    if (stop_at > 0 && stop_at < exp_q.size()) begin
      prev = exp_q[stop_at-1];
      while (exp_q.size() > stop_at) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, prev.idx, 0, 1, 0, 0));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0 && i == frz_at) begin
        ena = 1'b0; start = 1'b0; stop = 1'b0;
        for (int j = 0; j < frz_len; j++) begin
          step();
          e = exp_q[i-1];
          e.done = 1'b0; e.ft = 1'b0; e.cerr = 1'b0;
          chk($sformatf("%s_frz[%0d]", tag, i), 32'(cur_obs()), 32'(e));
        end
        ena = 1'b1;
      end
      if (i > 0) begin
        scramble_cfg();
        start = exp_q[i-1].busy ? 1'($urandom_range(0, 1)) : 1'b0;
        stop  = (i == stop_at);
      end
      step();
      chk($sformatf("%s[%0d]", tag, i), 32'(cur_obs()), 32'(exp_q[i]));
    end
    start = 1'b0; stop = 1'b0;
    cur_idx = int'(exp_q[exp_q.size()-1].idx);
    for (int j = 0; j < 2; j++) begin
      stop = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("%s_idle%0d", tag, j), 32'(cur_obs()), 32'(mk(0, cur_idx, 0, 0, 0, 0)));
    end
    stop = 1'b0;
  endtask

  initial begin
    int m, f, l, dw, sa, fa;
    #3;
    chk("reset", 32'(cur_obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_idle", 32'(cur_obs()), 32'(mk(0, 0, 0, 0, 0, 0)));

    run(M_SCAN,   1, 3, 4,   -1, -1, 0, "scan13");
    run(M_SINGLE, 5, 0, 0,   -1, -1, 0, "single5_d0");
    run(M_CONT,   0, 1, 3,   13, -1, 0, "cont_stop_dwell");
    run(M_CONT,   0, 1, 3,   10, -1, 0, "cont_stop_wrap");
    run(M_SCAN,   4, 2, 3,   -1, -1, 0, "bad_order");
    run(M_SCAN,   0, 6, 3,   -1, -1, 0, "bad_last");
    run(M_SINGLE, 7, 0, 3,   -1, -1, 0, "bad_first");
    run(M_HOLD,   2, 0, 9,   20, 10, 5, "hold2");
    run(M_SINGLE, 0, 0, 255, -1, 100, 3, "single_d255");
    run(M_SCAN,   0, 5, 1,   -1, 7, 2, "scan_all_d1");

    // Asynchronous reset in the middle of a dwell.
    mode = 2'(M_SCAN); ch_first = 3'd0; ch_last = 3'd2; dwell = DW'(5); start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_dwell", 32'(cur_obs()), 32'(mk(1, 0, 1, 0, 0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(cur_obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cur_idx = 0;
    run(M_SCAN, 1, 3, 4, -1, -1, 0, "post_rst");

    for (int r = 0; r < 40; r++) begin
      m = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 15) begin
        f = int'($urandom_range(0, 7));
        l = int'($urandom_range(0, 7));
      end else begin
        f = int'($urandom_range(0, 5));
        l = int'($urandom_range(f, 5));
      end
      dw = int'($urandom_range(0, 6));
      if (m == M_CONT || m == M_HOLD) sa = int'($urandom_range(1, 50));
      else sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1;
      fa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
      run(m, f, l, dw, sa, fa, int'($urandom_range(1, 4)), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
